// File: rtl/exe_result_fifo_pkg.sv
// exe_result_fifo_pkg: shared result payload type and ROB id width
package exe_result_fifo_pkg;
  localparam int ROB_ID_W = 6;
  typedef struct packed {
    logic [31:0]         data;
    logic [ROB_ID_W-1:0] wreg_id;
    logic                jump;
    logic [31:0]         target;
  } exe_result_t;
endpackage

// File: rtl/exe_result_fifo_ring_ptr.sv
// ring_ptr: wrapping index over a power-of-two ring with increment and clear
module ring_ptr #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     inc_i,
  output logic [$clog2(DEPTH)-1:0] ptr_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] ptr_q, ptr_d;
  // clear wins over increment; power-of-two depth wraps naturally
  always_comb ptr_d = clr_i ? '0 : inc_i ? ptr_q + AW'(1) : ptr_q;
  // pointer register
  always_ff @(posedge clk)
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/exe_result_fifo.sv
// exe_result_fifo: in-order FU result buffer feeding the CDB arbiter; EXE_FIFO_BYPASS_EN adds an empty-FIFO pass-through
module exe_result_fifo
  import exe_result_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [31:0]                  in_data_i,
  input  logic [ROB_ID_W-1:0]          in_wreg_id_i,
  input  logic                         in_jump_i,
  input  logic [31:0]                  in_target_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [31:0]                  out_data_o,
  output logic [ROB_ID_W-1:0]          out_wreg_id_o,
  output logic                         out_jump_o,
  output logic [31:0]                  out_target_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  exe_result_t   mem_q [DEPTH];
  exe_result_t   in_res, out_res;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count_q, count_d;
  logic          empty, push, wr, rd;
  assign in_res = {in_data_i, in_wreg_id_i, in_jump_i, in_target_i};
  // handshake decode; in_ready looks only at registered state, never at out_ready
  always_comb begin
    empty      = count_q == '0;
    in_ready_o = count_q != CW'(DEPTH) && !flush_i;
    push       = in_valid_i && in_ready_o;
`ifdef EXE_FIFO_BYPASS_EN
    out_valid_o = (!empty || in_valid_i) && !flush_i;
    out_res     = empty ? in_res : mem_q[head];
    wr          = push && !(empty && out_ready_i);
    rd          = out_valid_o && out_ready_i && !empty;
`else
    out_valid_o = !empty && !flush_i;
    out_res     = mem_q[head];
    wr          = push;
    rd          = out_valid_o && out_ready_i;
`endif
    count_d     = flush_i ? '0 : count_q + CW'(wr) - CW'(rd);
  end
  // payload storage, intentionally not reset
  always_ff @(posedge clk)
    if (wr) mem_q[tail] <= in_res;
  // occupancy counter
  always_ff @(posedge clk)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  ring_ptr #(.DEPTH(DEPTH)) u_head (.clk(clk), .rst_n(rst_n), .clr_i(flush_i), .inc_i(rd), .ptr_o(head));
  ring_ptr #(.DEPTH(DEPTH)) u_tail (.clk(clk), .rst_n(rst_n), .clr_i(flush_i), .inc_i(wr), .ptr_o(tail));
  assign out_data_o    = out_res.data;
  assign out_wreg_id_o = out_res.wreg_id;
  assign out_jump_o    = out_res.jump;
  assign out_target_o  = out_res.target;
  assign count_o       = count_q;
endmodule

// File: tb/tb_exe_result_fifo.sv
// tb_exe_result_fifo: scoreboard bench for exe_result_fifo, bypass-aware via EXE_FIFO_BYPASS_EN
module tb_exe_result_fifo;
  import exe_result_fifo_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0, flush_i = 0, in_valid_i = 0, in_jump_i = 0, out_ready_i = 0;
  logic [31:0] in_data_i = 0, in_target_i = 0;
  logic [ROB_ID_W-1:0] in_wreg_id_i = 0;
  logic in_ready_o, out_valid_o, out_jump_o;
  logic [31:0] out_data_o, out_target_o;
  logic [ROB_ID_W-1:0] out_wreg_id_o;
  logic [2:0] count_o;
  int vectors = 0, miscompares = 0;
  exe_result_t q[$];

  exe_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
    .in_wreg_id_i(in_wreg_id_i), .in_jump_i(in_jump_i), .in_target_i(in_target_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_wreg_id_o(out_wreg_id_o), .out_jump_o(out_jump_o), .out_target_o(out_target_o),
    .count_o(count_o));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exe_result_t mk(input logic [31:0] d);
    exe_result_t r;
    r.data    = d;
    r.wreg_id = d[ROB_ID_W-1:0] ^ 6'h2A;
    r.jump    = d[0];
    r.target  = ~d;
    return r;
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic rdy, input logic fl);
    exe_result_t r, e;
    logic exp_ir, exp_ov, byp;
    r = mk(d);
    in_valid_i = v; in_data_i = r.data; in_wreg_id_i = r.wreg_id;
    in_jump_i = r.jump; in_target_i = r.target; out_ready_i = rdy; flush_i = fl;
    @(negedge clk);
    exp_ir = q.size() != DEPTH && !fl;
    byp = 1'b0;
`ifdef EXE_FIFO_BYPASS_EN
    byp = q.size() == 0 && !fl;
`endif
    exp_ov = byp ? v : (q.size() != 0 && !fl);
    check("count", 64'(count_o), 64'(q.size()));
    check("in_ready", 64'(in_ready_o), 64'(exp_ir));
    check("out_valid", 64'(out_valid_o), 64'(exp_ov));
    if (exp_ov && rdy) begin
      e = byp ? r : q[0];
      check("out_data", 64'(out_data_o), 64'(e.data));
      check("out_wreg_id", 64'(out_wreg_id_o), 64'(e.wreg_id));
      check("out_jump", 64'(out_jump_o), 64'(e.jump));
      check("out_target", 64'(out_target_o), 64'(e.target));
    end
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (exp_ov && rdy && !byp) void'(q.pop_front());
      if (v && exp_ir && !(byp && rdy)) q.push_back(r);
    end
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    step(1'b0, 32'h0, 1'b0, 1'b0);
    // fill to full, fifth push refused, then drain in order
    step(1'b1, 32'h11, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b1, 32'h44, 1'b0, 1'b0);
    step(1'b1, 32'h55, 1'b0, 1'b0);
    check("full_count", 64'(count_o), 64'd4);
    drain();
    check("drained_count", 64'(count_o), 64'd0);
    // streaming at count 2 across pointer wrap
    step(1'b1, 32'h101, 1'b0, 1'b0);
    step(1'b1, 32'h102, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0);
      check("stream_count", 64'(count_o), 64'd2);
    end
    drain();
    // full with simultaneous pop: push refused, count drops to 3
    for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    step(1'b1, 32'h399, 1'b1, 1'b0);
    check("full_pop_count", 64'(count_o), 64'd3);
    // flush with a concurrent push: everything discarded
    step(1'b1, 32'h777, 1'b0, 1'b1);
    check("flush_count", 64'(count_o), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 32'h888, 1'b0, 1'b0);
    drain();
    // reset mid-stream with count 2
    step(1'b1, 32'h401, 1'b0, 1'b0);
    step(1'b1, 32'h402, 1'b0, 1'b0);
    rst_n = 0; in_valid_i = 1; in_data_i = 32'h403;
    @(posedge clk);
    #1 rst_n = 1;
    q.delete();
    check("rst_count", 64'(count_o), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // empty FIFO with ready consumer: bypass or one-cycle latency
    step(1'b1, 32'hABCD, 1'b1, 1'b0);
`ifdef EXE_FIFO_BYPASS_EN
    check("bypass_count", 64'(count_o), 64'd0);
`else
    check("nobypass_count", 64'(count_o), 64'd1);
`endif
    step(1'b0, 32'h0, 1'b1, 1'b0);
    // randomized traffic with occasional flush
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exe_result_fifo.md
# exe_result_fifo

Per-IQ result buffer between an issue queue's execute stage and the common-data-bus (CDB) arbiter. It accepts one execution result per cycle from the FU behind the ALU issue queue and holds up to DEPTH results in order. Results drain to the CDB arbiter through a valid/ready handshake, and `in_ready` is the back-pressure (FIFO-ready) signal that gates issue in the IQ.

## Interface
- DEPTH, 4, number of result entries; power of two, ≥2
- ROB_ID_W, 6, width of the destination ROB/wreg id
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush; discards all buffered results
- in_valid  in  1  FU result valid this cycle
- in_ready  out  1  FIFO can accept a result this cycle
- in_data  in  32  result data
- in_wreg_id  in  ROB_ID_W  destination ROB id
- in_jump  in  1  branch taken/redirect flag
- in_target  in  32  jump target PC
- out_valid  out  1  head entry presented to CDB arbiter
- out_ready  in  1  CDB arbiter grants this port
- out_data, out_wreg_id, out_jump, out_target  out  32/ROB_ID_W/1/32  head entry fields
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer: head (read) and tail (write) pointers, $clog2(DEPTH) bits each, wrap from DEPTH-1 to 0; separate occupancy counter `count`.
- Push when in_valid & in_ready; pop when out_valid & out_ready.
- in_ready = (count != DEPTH) & !flush. It depends only on registered state, never on out_ready: a full FIFO refuses a push even in a cycle where it pops.
- out_valid = (count != 0) & !flush; out_* = entry[head].
- Push and pop in the same cycle: both pointers advance, count unchanged.
- in_valid while !in_ready: the payload is ignored and no state changes. The upstream IQ must hold the result.
- flush: sets count, head and tail to 0 at the next edge; overrides any push or pop in that cycle. out_valid and in_ready are low during the flush cycle.
- Entry payload RAM is not reset. Only pointers and count are reset.
- Reset values: count=0, out_valid=0, in_ready=1, out_* don't-care (0 in simulation is acceptable).

## Timing
- Push to out_valid latency: 1 cycle (result visible the cycle after acceptance), unless bypass is configured.
- Throughput: 1 push + 1 pop per cycle sustained.
- count updates at the edge following the handshake.
- Reset during operation: all buffered results are lost. in_ready=1 the cycle after reset deasserts.

## Configuration
- EXE_FIFO_BYPASS_EN defined: when count==0 and !flush, out_valid = in_valid and out_* = in_*, combinationally in the same cycle.
  - If out_ready is also high, the result is consumed without being written; tail and count do not change.
  - If out_ready is low, the result is written normally.
  - This adds an in_valid→out_valid combinational path.
- Not defined: there is no combinational in→out path, and the minimum latency is 1 cycle.

## Structure
- The shared package holds:
  - `exe_result_t` (data, wreg_id, jump, target)
  - ROB_ID_W
- Internally, storage is an `exe_result_t` array.
- One sub-module is natural: `ring_ptr`, a wrapping pointer with an increment enable and clear, instantiated for head and tail.

## Test plan
- **Fill/drain:** DEPTH=4, out_ready=0, push data 0x11..0x44 on consecutive cycles.
  - in_ready drops after the 4th push and count=4.
  - A 5th push (0x55) is ignored.
  - Then with out_ready=1, out_data reads 0x11, 0x22, 0x33, 0x44 on consecutive cycles, and count ends at 0.
- **Simultaneous push/pop at count=2:** count stays 2, order is preserved, and pointers wrap correctly across index 3→0 over 10 cycles of streaming.
- **Full + pop:** with count=4, in_valid=1 and out_ready=1:
  - the pop occurs and the push is rejected (in_ready=0);
  - count=3 next cycle.
- **Flush:** with count=3, assert flush together with in_valid=1.
  - out_valid and in_ready are 0 that cycle.
  - Next cycle count=0, out_valid=0, and the flushed-cycle input is absent.
- **Reset mid-stream:** with count=2, assert rst_n=0 for 1 cycle.
  - Next cycle count=0, out_valid=0, in_ready=1.
- **Bypass (EXE_FIFO_BYPASS_EN):** with empty FIFO, in_valid=1, in_data=0xABCD and out_ready=1:
  - out_valid=1 and out_data=0xABCD in the same cycle;
  - count remains 0.
  - Without the macro, out_valid rises one cycle later.
